// File: rtl/cic_comp_pkg.sv
// Shared types, coefficient table and saturation helpers for the CIC droop-compensation FIR.
package cic_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_e;

  localparam int DEFAULT_TAPS = 16;

  // Symmetric Q1.11 droop-compensation taps; the sum is 2048, which gives unity DC gain.
  localparam logic signed [11:0] COEFFS [DEFAULT_TAPS] = '{
    -12'sd6,   12'sd10,  12'sd14,  -12'sd26,
    -12'sd50,  12'sd60,  12'sd250,  12'sd772,
     12'sd772, 12'sd250, 12'sd60,  -12'sd50,
    -12'sd26,  12'sd14,  12'sd10,  -12'sd6
  };

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/cic_comp_delay_line.sv
// Circular sample buffer for the compensation FIR: one write port, one combinational read port.
module cic_comp_delay_line #(
  parameter int NUM_TAPS    = 16,
  parameter int INPUT_WIDTH = 12,
  localparam int PTR_W      = $clog2(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          wr_en,
  input  logic [PTR_W-1:0]              wr_ptr,
  input  logic signed [INPUT_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]              rd_ptr,
  output logic signed [INPUT_WIDTH-1:0] rd_data
);

  logic signed [INPUT_WIDTH-1:0] mem_q [NUM_TAPS];
  logic signed [INPUT_WIDTH-1:0] mem_d [NUM_TAPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/cic_comp_fir.sv
// Single-MAC CIC droop-compensation FIR driven by an edge-detected decimated clock.
// Define CIC_COMP_SATURATE_EN to saturate the output instead of wrapping it.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int COEFF_WIDTH  = 12,
  parameter int NUM_TAPS     = DEFAULT_TAPS,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic signed [INPUT_WIDTH-1:0]  data_in,
  input  logic                           data_clk,
  output logic signed [OUTPUT_WIDTH-1:0] data_out,
  output logic                           data_valid,
  output logic                           overrun
);

  localparam int PTR_W = $clog2(NUM_TAPS);
  localparam int SHIFT = COEFF_WIDTH - 1;
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (SHIFT - 1);

  state_e                          state_q, state_d;
  logic                            data_clk_q;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                tap_q, tap_d;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic signed [OUTPUT_WIDTH-1:0]  data_out_q, data_out_d;
  logic                            data_valid_q, data_valid_d;
  logic                            overrun_q, overrun_d;

  logic                                      sample_edge;
  logic                                      wr_en;
  logic signed [INPUT_WIDTH-1:0]             rd_sample;
  logic signed [COEFF_WIDTH-1:0]             coeff;
  logic signed [INPUT_WIDTH+COEFF_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]               acc_biased;
  logic signed [OUTPUT_WIDTH-1:0]            narrowed;

  cic_comp_delay_line #(
    .NUM_TAPS    (NUM_TAPS),
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_delay_line (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (data_in),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_sample)
  );

  assign sample_edge = data_clk & ~data_clk_q;
  assign coeff       = COEFF_WIDTH'(COEFFS[tap_q]);
  assign product     = rd_sample * coeff;

  // Round half up before narrowing to the output width.
  always_comb begin
`ifdef CIC_COMP_SATURATE_EN
    logic signed [63:0] rounded_ext;
`endif
    acc_biased = acc_q + HALF;
`ifdef CIC_COMP_SATURATE_EN
    rounded_ext = 64'(acc_biased >>> SHIFT);
    if (rounded_ext > sat_max(OUTPUT_WIDTH)) begin
      narrowed = OUTPUT_WIDTH'(sat_max(OUTPUT_WIDTH));
    end else if (rounded_ext < sat_min(OUTPUT_WIDTH)) begin
      narrowed = OUTPUT_WIDTH'(sat_min(OUTPUT_WIDTH));
    end else begin
      narrowed = OUTPUT_WIDTH'(rounded_ext);
    end
`else
    narrowed = OUTPUT_WIDTH'(acc_biased >>> SHIFT);
`endif
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_edge) begin
          wr_en    = 1'b1;
          acc_d    = '0;
          tap_d    = '0;
          rd_ptr_d = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_TAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
          state_d  = MAC;
        end
      end
      MAC: begin
        // Walk backwards from the newest sample so it pairs with COEFFS[0].
        acc_d    = acc_q + ACC_WIDTH'(product);
        rd_ptr_d = (rd_ptr_q == '0) ? PTR_W'(NUM_TAPS - 1) : rd_ptr_q - PTR_W'(1);
        tap_d    = tap_q + PTR_W'(1);
        if (tap_q == PTR_W'(NUM_TAPS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_out_d   = narrowed;
        data_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sample_edge && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      data_clk_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_clk_q   <= data_clk;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Sequential single-MAC FIR that compensates CIC passband droop. Sits directly downstream of the 5-stage CIC decimator.
- Consumes the decimator's 12-bit signed output and its decimated output clock (≈50% duty, one rising edge per output sample). Produces compensated samples with a one-cycle valid strobe for the demodulator/audio stage.
- Runs entirely in the system clock domain. The decimated clock is treated as data and edge-detected; it never clocks flops.

Parameters:
- INPUT_WIDTH, 12, width of signed input sample.
- OUTPUT_WIDTH, 12, width of signed output sample.
- COEFF_WIDTH, 12, signed coefficient width, format Q1.(COEFF_WIDTH-1).
- NUM_TAPS, 16, number of taps (even, ≥4). Coefficients are symmetric and sum to 2^(COEFF_WIDTH-1), giving unity DC gain.
- ACC_WIDTH, 32, accumulator width. Must be ≥ INPUT_WIDTH+COEFF_WIDTH+$clog2(NUM_TAPS).

Ports:
- clk  input  1  system clock
- arst  input  1  asynchronous reset, active-high
- data_in  input  INPUT_WIDTH  signed sample from CIC, stable while data_clk high
- data_clk  input  1  CIC decimated clock; its rising edge marks a new sample
- data_out  output  OUTPUT_WIDTH  signed compensated sample, held between updates
- data_valid  output  1  one-cycle pulse when data_out updates
- overrun  output  1  sticky; set when a sample edge arrives while the MAC is busy

Behaviour:
Reset:
- data_out=0, data_valid=0, overrun=0.
- All NUM_TAPS delay-line entries = 0, write pointer = 0, accumulator = 0, data_clk_q = 0, state = IDLE.
- Reset asserted mid-MAC aborts the computation; no data_valid is produced for that sample.

Edge detect:
- sample_edge = data_clk & ~data_clk_q, where data_clk_q is a 1-cycle delayed copy.
- Call the cycle in which sample_edge=1 cycle E.

FSM states IDLE, MAC, ROUND:
- IDLE
  - On sample_edge: write data_in into the circular buffer at wr_ptr; clear acc; tap index k=0; read pointer = wr_ptr; advance wr_ptr (wraps NUM_TAPS-1 → 0); go to MAC.
- MAC
  - Each cycle: acc += sample[rd_ptr] * COEFFS[k]. rd_ptr decrements with wrap, so the newest sample pairs with COEFFS[0].
  - After k=NUM_TAPS-1, go to ROUND. MAC occupies exactly NUM_TAPS cycles.
- ROUND
  - data_out <= narrow((acc + 2^(COEFF_WIDTH-2)) >>> (COEFF_WIDTH-1)), i.e. round half up.
  - data_valid <= 1 for one cycle; go to IDLE.

Latency:
- data_valid is high in cycle E+NUM_TAPS+2, i.e. 18 cycles after the edge at defaults.

Overrun:
- sample_edge while state≠IDLE: the sample is dropped, buffer untouched, overrun set until arst.
- A sample_edge in the same cycle the FSM returns to IDLE (ROUND cycle) counts as busy and is dropped.

Arithmetic:
- Products are signed full precision, sign-extended into ACC_WIDTH. No intermediate truncation.

Optional Feature:
- Macro: CIC_COMP_SATURATE_EN.
- Defined: narrow() saturates to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- Undefined: narrow() takes the low OUTPUT_WIDTH bits (two's-complement wrap). This saves the comparators.

Decomposition:
- Package cic_comp_pkg holds:
  - state enum (IDLE, MAC, ROUND);
  - COEFFS localparam array for the default 16-tap design, symmetric, summing to 2048;
  - helper function for the saturation bounds.
- Sub-module cic_comp_delay_line: NUM_TAPS × INPUT_WIDTH circular buffer with async-reset-to-zero, one write port and one combinational read port.
- The top module holds edge detect, FSM, MAC and output rounding.

Test Plan:
- Impulse: after reset, one data_clk edge with data_in=1024, then edges with data_in=0 every 32 cycles.
  - Output n equals round(COEFFS[n]*1024/2048) for n=0..15, then 0.
  - Each data_valid occurs exactly 18 cycles after its edge.
- DC: constant data_in=1000 for 20 edges → data_out=1000 from the 16th output onward. overrun stays 0.
- Full scale with macro defined: data_in=2047 constant → data_out settles at 2047 with no wrap. Any overshoot taps clamp at 2047.
  - Same stimulus with -2048 → -2048.
  - Without the macro, an overshooting coefficient set shows the wrapped value.
- Overrun: second data_clk edge 10 cycles after the first.
  - Only one data_valid is produced; overrun=1 from that cycle on.
  - The following edge 40 cycles later still produces a correct output.
- Reset mid-operation: assert arst 5 cycles into MAC.
  - data_out=0, data_valid=0, overrun=0 immediately.
  - No stale data_valid after release; the next impulse reproduces the impulse-test sequence from a clean delay line.
- Held data_clk: data_clk held high for 100 cycles yields exactly one sample and one data_valid. No retrigger without a 0→1 transition.
